// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: 4x4 matrix keypad column scanner.
// Strobes one column at a time and locks onto the first pressed key.
// Hands the locked key to the external debouncer.
// Turns each debounced key into a hex code and keeps a two-digit history.
module keypad_scan_controller #(
    parameter int unsigned SCAN_DIV = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_pressed,
    output logic [3:0] row_idx,
    output logic [3:0] col_idx,
    input  logic       key_valid,
    input  logic [3:0] key_row,
    input  logic [3:0] key_col,
    output logic       new_key,
    output logic [3:0] key_code,
    output logic [3:0] digit_cur,
    output logic [3:0] digit_prev
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_HOLD,
        ST_REGISTER,
        ST_RELEASE
    } state_t;

    state_t           state_q;
    logic [3:0]       rows_s1_q;
    logic [3:0]       rows_s2_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       col_sel_q;
    logic             kv_q;
    logic             key_pressed_q;
    logic [3:0]       row_idx_q;
    logic [3:0]       col_idx_q;
    logic             new_key_q;
    logic [3:0]       key_code_q;
    logic [3:0]       digit_cur_q;
    logic [3:0]       digit_prev_q;

    logic [3:0] prs;
    logic       tick;
    logic       hit;
    logic       kv_rise;
    logic [3:0] row_pick;
    logic [1:0] r_enc;
    logic [1:0] c_enc;
    logic       key_ok;
    logic [3:0] key_code_d;

    // Scan decode: active-high rows, dwell tick, priority row pick and key-to-hex mapping
    always_comb begin
        prs     = ~rows_s2_q;
        tick    = (div_q == DIV_LAST);
        hit     = |(prs & row_idx_q);
        kv_rise = key_valid & ~kv_q;

        row_pick = 4'b0000;
        if (prs[0])      row_pick = 4'b0001;
        else if (prs[1]) row_pick = 4'b0010;
        else if (prs[2]) row_pick = 4'b0100;
        else if (prs[3]) row_pick = 4'b1000;

        r_enc = 2'd0;
        case (key_row)
            4'b0010: r_enc = 2'd1;
            4'b0100: r_enc = 2'd2;
            4'b1000: r_enc = 2'd3;
            default: r_enc = 2'd0;
        endcase
        c_enc = 2'd0;
        case (key_col)
            4'b0010: c_enc = 2'd1;
            4'b0100: c_enc = 2'd2;
            4'b1000: c_enc = 2'd3;
            default: c_enc = 2'd0;
        endcase
        key_ok = $onehot(key_row) && $onehot(key_col);

        case ({r_enc, c_enc})
            4'b00_00: key_code_d = 4'h1;
            4'b00_01: key_code_d = 4'h2;
            4'b00_10: key_code_d = 4'h3;
            4'b00_11: key_code_d = 4'hA;
            4'b01_00: key_code_d = 4'h4;
            4'b01_01: key_code_d = 4'h5;
            4'b01_10: key_code_d = 4'h6;
            4'b01_11: key_code_d = 4'hB;
            4'b10_00: key_code_d = 4'h7;
            4'b10_01: key_code_d = 4'h8;
            4'b10_10: key_code_d = 4'h9;
            4'b10_11: key_code_d = 4'hC;
            4'b11_00: key_code_d = 4'hE;
            4'b11_01: key_code_d = 4'h0;
            4'b11_10: key_code_d = 4'hF;
            default:  key_code_d = 4'hD;
        endcase
    end

    // Synchronizer, edge detector and scan/lock/register FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SCAN;
            rows_s1_q     <= '1;
            rows_s2_q     <= '1;
            div_q         <= '0;
            col_sel_q     <= 4'b0001;
            kv_q          <= 1'b0;
            key_pressed_q <= 1'b0;
            row_idx_q     <= '0;
            col_idx_q     <= '0;
            new_key_q     <= 1'b0;
            key_code_q    <= '0;
            digit_cur_q   <= '0;
            digit_prev_q  <= '0;
        end else begin
            rows_s1_q <= rows;
            rows_s2_q <= rows_s1_q;
            kv_q      <= key_valid;
            new_key_q <= 1'b0;

            case (state_q)
                ST_SCAN: begin
                    key_pressed_q <= 1'b0;
                    if (tick) begin
                        div_q <= '0;
                        if (prs != 4'b0000) begin
                            row_idx_q     <= row_pick;
                            col_idx_q     <= col_sel_q;
                            key_pressed_q <= 1'b1;
                            state_q       <= ST_HOLD;
                        end else begin
                            col_sel_q <= {col_sel_q[2:0], col_sel_q[3]};
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    div_q <= '0;
                    // a release on the same edge as the key_valid rise takes priority
                    if (!hit) begin
                        key_pressed_q <= 1'b0;
                        state_q       <= ST_SCAN;
                    end else if (kv_rise) begin
                        state_q <= ST_REGISTER;
                    end
                end
                ST_REGISTER: begin
                    div_q <= '0;
                    if (key_ok) begin
                        new_key_q    <= 1'b1;
                        key_code_q   <= key_code_d;
                        digit_prev_q <= digit_cur_q;
                        digit_cur_q  <= key_code_d;
                    end
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    div_q         <= '0;
                    key_pressed_q <= hit;
                    if (!hit && !key_valid) begin
                        state_q <= ST_SCAN;
                    end
                end
                default: begin
                    state_q <= ST_SCAN;
                    div_q   <= '0;
                end
            endcase
        end
    end

    assign cols        = ~col_sel_q;
    assign key_pressed = key_pressed_q;
    assign row_idx     = row_idx_q;
    assign col_idx     = col_idx_q;
    assign new_key     = new_key_q;
    assign key_code    = key_code_q;
    assign digit_cur   = digit_cur_q;
    assign digit_prev  = digit_prev_q;

endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequencer for the 4x4 matrix keypad. It drives the column strobes and samples the row lines. It locks onto a pressed key and presents its one-hot row/column to `keypad_debouncer` as `key_pressed`/`row_idx`/`col_idx`. When the debouncer returns `key_valid`, it converts that key to a hex code and keeps a two-digit history for the seven-segment display path.

## Interface
Parameters:
- `SCAN_DIV`, default 3000: clk cycles per column dwell (1 ms at 3 MHz); legal range ≥ 4.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `rows`  in  4  raw keypad row lines, active-low (pulled up); asynchronous.
- `cols`  out  4  column strobes, active-low, exactly one low at all times.
- `key_pressed`  out  1  to debouncer: a candidate key is currently held.
- `row_idx`  out  4  to debouncer: one-hot locked row.
- `col_idx`  out  4  to debouncer: one-hot locked column.
- `key_valid`  in  1  from debouncer: debounced key accepted.
- `key_row`  in  4  from debouncer: one-hot row of the accepted key.
- `key_col`  in  4  from debouncer: one-hot column of the accepted key.
- `new_key`  out  1  one-cycle pulse when a key is registered.
- `key_code`  out  4  hex code of the last registered key.
- `digit_cur`  out  4  most recent key code.
- `digit_prev`  out  4  previous key code.

## Operation
- Rows pass through a 2-flop synchronizer, then are inverted to active-high `prs[3:0]`.
- Dwell counter `div` counts 0..SCAN_DIV-1. `tick` = (`div`==SCAN_DIV-1). The counter free-runs in SCAN and is cleared on any state change.
- Column select `col_sel` is one-hot. `cols` = ~`col_sel`.
- FSM states:
  - SCAN: `key_pressed`=0.
    - On `tick` with `prs`≠0: latch `row_idx` = lowest set bit of `prs` (row0 has priority), latch `col_idx`=`col_sel`, go to HOLD.
    - On `tick` with `prs`=0: rotate `col_sel` 0→1→2→3→0.
  - HOLD: `col_sel` frozen, `key_pressed`=1.
    - If `prs & row_idx` = 0: drop `key_pressed` and go to SCAN. `col_sel` advances on the next tick.
    - Else on `key_valid` rising edge (registered previous value): go to REGISTER.
  - REGISTER (1 cycle): decode `key_row`/`key_col`.
    - If both are one-hot: `new_key`=1, `key_code`=code, `digit_prev`←`digit_cur`, `digit_cur`←code.
    - Otherwise: no pulse, registers unchanged.
    - Go to RELEASE. `key_pressed` stays 1.
  - RELEASE: `key_pressed`=1 while `prs & row_idx`≠0, 0 otherwise. Go to SCAN when `prs & row_idx`=0 and `key_valid`=0.
- Keymap (row, col):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- `key_valid` edges seen in SCAN or RELEASE are ignored; the edge detector still updates.
- Additional keys pressed while in HOLD or RELEASE are ignored; there is no rollover.
- Reset values:
  - `cols`=4'b1110
  - `key_pressed`=0, `row_idx`=0, `col_idx`=0
  - `new_key`=0, `key_code`=0, `digit_cur`=0, `digit_prev`=0
  - state SCAN, `div`=0, edge-detect register 0
- Reset asserted mid-operation returns all of the above immediately, regardless of state.

## Timing
- `rows` to `prs` latency: 2 clk.
- Each column dwells SCAN_DIV cycles. Rows are sampled only at `tick`, giving ≥ SCAN_DIV-2 cycles of settling after a strobe change.
- SCAN→HOLD: `key_pressed`, `row_idx`, `col_idx` are registered and asserted the cycle after `tick`.
- Release detection in HOLD: `key_pressed` falls 1 clk after `prs` clears, i.e. 3 clk after the `rows` line returns high.
- `new_key` rises exactly 2 clk after the first `key_valid`=1 cycle:
  - 1 clk for the edge register;
  - 1 clk for REGISTER.
- `key_code`/`digit_*` update on the same edge on which `new_key` rises.
- `new_key` is never high on two consecutive cycles.
- Simultaneous `key_valid` rise and row release in HOLD: release wins, go to SCAN, no `new_key`.
- Worst-case scan latency for one full rotation: 4·SCAN_DIV clk.

## Test plan
SCAN_DIV=4 for all scenarios; the bench models the keypad matrix and a behavioural debouncer.

- Reset, idle 40 clk → `cols` rotates 1110→1101→1011→0111→1110, each pattern held 4 clk; `key_pressed`=0 throughout.
- Press (row1, col2) → `key_pressed`=1, `row_idx`=0010, `col_idx`=0100, `cols` frozen at 1011. Then `key_valid`=1 with `key_row`=0010, `key_col`=0100 → exactly one `new_key` pulse, `key_code`=6, `digit_cur`=6.
- Register keys 6 then A → `digit_prev`=6, `digit_cur`=A. Release key → scanning resumes once `key_valid`=0.
- Press row0 and row2 simultaneously in col0 → `row_idx`=0001; `key_valid` with row0/col0 → `key_code`=1.
- Release row in HOLD before `key_valid` rises → `key_pressed` falls 3 clk after release, no `new_key`, scanning resumes. Separately, `key_valid` with `key_row`=0011 → no pulse, outputs unchanged.
- Assert `rst` while in RELEASE with `digit_cur`=5 → all outputs at reset values within the same cycle; scanning restarts from `cols`=1110.
